// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
// The max_value helper sets the overflow threshold for a given digit count.
package bin2bcd_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int BIN_W_DEF  = 27;
    localparam int DIGITS_DEF = 8;

    // Value shown on every digit when the input cannot be represented.
    localparam logic [3:0] NIBBLE_NINE = 4'h9;

    function automatic logic [63:0] max_value(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // The largest possible result is 9+3=12, so a 4-bit add never wraps.
    always_comb begin
        dout = (din >= 4'd5) ? (din + 4'd3) : din;
    end

endmodule

// File: rtl/bin2bcd_iter.sv
// Sequential binary-to-BCD converter, one double-dabble bit per clock. The
// result, leading-zero blank mask and overflow flag are held for the display.
module bin2bcd_iter
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [DIGITS-1:0]     out_blank,
    output logic                  out_ovf,
    output logic                  done
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [63:0]      MAX_VAL   = max_value(DIGITS);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [SR_W-1:0]      sr;
    logic                 ovf_q;

    logic                 accept;
    logic                 commit;

    logic [BCD_W-1:0]     adj_bcd;
    logic [SR_W-1:0]      sr_pre;
    logic [SR_W-1:0]      sr_next;

    logic [BCD_W-1:0]     commit_bcd;
    logic [DIGITS-1:0]    commit_blank;
    logic                 all_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = CONV;
            CONV:    if (cnt == LAST_ITER) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Commit is the edge that completes the final iteration.
    always_comb begin
        in_ready = (state == IDLE);
        accept   = (state == IDLE) && in_valid;
        commit   = (state == CONV) && (cnt == LAST_ITER);
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (sr[BIN_W + 4*d +: 4]),
            .dout (adj_bcd[4*d +: 4])
        );
    end

    always_comb begin
        sr_pre  = {adj_bcd, sr[BIN_W-1:0]};
        sr_next = sr_pre << 1;
    end

    // Digit i blanks only when it and every digit above it are zero; the
    // least significant digit always shows so zero reads as a single "0".
    always_comb begin
        commit_bcd   = ovf_q ? {DIGITS{NIBBLE_NINE}} : sr_next[SR_W-1 -: BCD_W];
        commit_blank = '0;
        all_zero     = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero        = all_zero && (commit_bcd[4*i +: 4] == 4'd0);
            commit_blank[i] = all_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            sr    <= {{BCD_W{1'b0}}, in_bin};
            cnt   <= '0;
            ovf_q <= (64'(in_bin) > MAX_VAL);
        end else if (state == CONV) begin
            sr    <= sr_next;
            cnt   <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_bcd   <= '0;
            out_blank <= {{(DIGITS-1){1'b1}}, 1'b0};
            out_ovf   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= commit;
            if (commit) begin
                out_bcd   <= commit_bcd;
                out_blank <= commit_blank;
                out_ovf   <= ovf_q;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Directed self-checking bench for bin2bcd_iter: conversions, blanking,
// saturation, back-to-back spacing, ignored mid-conversion input and reset abort.
module tb_bin2bcd_iter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] in_bin;
    logic [31:0] out_bcd;
    logic [7:0]  out_blank;
    logic        out_ovf;
    logic        done;

    int passCount;
    int checkCount;
    int doneSeen;
    int doneBase;
    time tAcc0;
    time tAcc1;
    time tAcc2;

    bin2bcd_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_bcd   (out_bcd),
        .out_blank (out_blank),
        .out_ovf   (out_ovf),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) doneSeen++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic checkResult(input logic [31:0] expBcd, input logic [7:0] expBlank, input logic expOvf);
        checkOutput("out_bcd", 64'(out_bcd), 64'(expBcd));
        checkOutput("out_blank", 64'(out_blank), 64'(expBlank));
        checkOutput("out_ovf", 64'(out_ovf), 64'(expOvf));
    endtask

    // Caller sits just after a clock edge with the converter idle.
    task automatic applyStimulus(input logic [26:0] v, input bit holdValid, input bit scramble,
                                 output time tAcc);
        int cyc;
        bit got;
        bit stable;
        logic [31:0] snap;
        checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_bin   = v;
        in_valid = 1'b1;
        @(posedge clk);
        tAcc = $time;
        #1;
        if (!holdValid) in_valid = 1'b0;
        cyc    = 0;
        got    = 1'b0;
        stable = 1'b1;
        snap   = out_bcd;
        while (!got && cyc < 40) begin
            if (scramble) in_bin = 27'($urandom);
            @(posedge clk);
            #1;
            cyc++;
            if (done) got = 1'b1;
            else if (out_bcd !== snap) stable = 1'b0;
        end
        checkOutput("latency", 64'(cyc), 64'd27);
        checkOutput("stable_mid_conversion", 64'(stable), 64'd1);
    endtask

    initial begin
        time tDummy;
        passCount  = 0;
        checkCount = 0;
        doneSeen   = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_bin     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkResult(32'h0, 8'hFE, 1'b0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

        applyStimulus(27'd12345678, 1'b0, 1'b0, tDummy);
        checkResult(32'h12345678, 8'h00, 1'b0);

        applyStimulus(27'd0, 1'b1, 1'b0, tAcc0);
        checkResult(32'h0, 8'hFE, 1'b0);
        applyStimulus(27'd1, 1'b1, 1'b0, tAcc1);
        checkResult(32'h1, 8'hFE, 1'b0);
        applyStimulus(27'd907, 1'b0, 1'b0, tAcc2);
        checkResult(32'h907, 8'hF8, 1'b0);
        checkOutput("b2b_gap_0_1", 64'(tAcc1 - tAcc0), 64'd280);
        checkOutput("b2b_gap_1_2", 64'(tAcc2 - tAcc1), 64'd280);

        applyStimulus(27'd99999999, 1'b0, 1'b0, tDummy);
        checkResult(32'h99999999, 8'h00, 1'b0);
        applyStimulus(27'd100000000, 1'b0, 1'b0, tDummy);
        checkResult(32'h99999999, 8'h00, 1'b1);
        applyStimulus(27'h7FFFFFF, 1'b0, 1'b0, tDummy);
        checkResult(32'h99999999, 8'h00, 1'b1);

        // Abort a conversion part-way and confirm nothing of it survives.
        in_bin   = 27'd55555555;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        doneBase = doneSeen;
        rst = 1'b1;
        #1;
        checkResult(32'h0, 8'hFE, 1'b0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 64'(doneSeen), 64'(doneBase));
        checkResult(32'h0, 8'hFE, 1'b0);

        applyStimulus(27'd42, 1'b0, 1'b0, tDummy);
        checkResult(32'h42, 8'hFC, 1'b0);

        applyStimulus(27'd24680, 1'b1, 1'b1, tDummy);
        in_valid = 1'b0;
        checkResult(32'h24680, 8'hE0, 1'b0);

        @(posedge clk);
        #1;
        checkOutput("done_single_cycle", 64'(done), 64'd0);
        checkOutput("done_pulse_count", 64'(doneSeen), 64'd9);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
